logic_unit_arbiter: RTL and testbench

- Shares one combinational logic unit (AND/OR/XOR/NOR/pass-A) between two requesters: port 0 (EX pipeline) and port 1 (debug/microcode sequencer).
- Round-robin grant with valid/ready handshakes on the request and response sides.
- Operands and function code are registered, the unit output is captured after a programmable settle time, and the result is returned to the granted requester.
- The unit itself stays outside this block; the arbiter drives its A/B/FT inputs and samples its S output.

---
 rtl/logic_unit_pkg.sv | 27 ++
 rtl/logic_unit_arbiter_rr_arb2.sv | 20 ++
 rtl/logic_unit_arbiter.sv | 125 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: function codes, FSM states
// and the legality check used when a request is accepted.
package logic_unit_pkg;

  localparam logic [3:0] FT_AND    = 4'b1000;
  localparam logic [3:0] FT_OR     = 4'b1110;
  localparam logic [3:0] FT_XOR    = 4'b0110;
  localparam logic [3:0] FT_NOR    = 4'b0001;
  localparam logic [3:0] FT_PASS_A = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal_ft(input logic [3:0] ft);
    logic legal;
    legal = 1'b0;
    case (ft)
      FT_AND, FT_OR, FT_XOR, FT_NOR, FT_PASS_A: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; when both ask,
// the one named by prio_i wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] grant_o
);

  // Pick the winner from the current request pattern and priority
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external combinational logic unit between the EX pipeline
// (requester 0) and the debug/microcode sequencer (requester 1). Operands are
// registered onto the unit, held for SETTLE_CYCLES, then the unit result is
// captured and handed back to whichever requester owns the operation.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_ft0,
  input  logic [3:0]       req_ft1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic [3:0]       unit_ft,
  input  logic [WIDTH-1:0] unit_s
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             prio_q;
  logic             owner_q;
  logic [3:0]       cnt_q;
  logic             errFlag_q;
  logic [WIDTH-1:0] rspData_q;
  logic             rspErr_q;
  logic [WIDTH-1:0] unitA_q;
  logic [WIDTH-1:0] unitB_q;
  logic [3:0]       unitFt_q;

  logic [1:0]       grant;
  logic             winner;
  logic             reqFire;
  logic             rspFire;
  logic [3:0]       winFt;

  rr_arb2 u_rr_arb2 (
    .valid_i (req_valid),
    .prio_i  (prio_q),
    .grant_o (grant)
  );

  assign winner  = grant[1];
  assign reqFire = (state_q == IDLE) && (grant != 2'b00);
  assign rspFire = (state_q == RESP) && rsp_ready[owner_q];
  assign winFt   = winner ? req_ft1 : req_ft0;

  // State register; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept in IDLE, wait out the settle time, then wait for the owner
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reqFire) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rspFire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: grants only while idle, response only to the owner
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (state_q == IDLE) req_ready = grant;
    if (state_q == RESP) rsp_valid = owner_q ? 2'b10 : 2'b01;
  end

  // Datapath: latch operands on accept, count settle time, capture the unit result
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= 4'd0;
      errFlag_q <= 1'b0;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
      unitA_q   <= '0;
      unitB_q   <= '0;
      unitFt_q  <= FT_PASS_A;
    end else begin
      if (reqFire) begin
        unitFt_q  <= winFt;
        unitA_q   <= winner ? req_a1 : req_a0;
        unitB_q   <= winner ? req_b1 : req_b0;
        owner_q   <= winner;
        prio_q    <= ~winner;
        cnt_q     <= SETTLE_LOAD;
        errFlag_q <= ~is_legal_ft(winFt);
      end
      if (state_q == EXEC) begin
        if (cnt_q == 4'd0) begin
          rspData_q <= unit_s;
          rspErr_q  <= errFlag_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign rsp_data = rspData_q;
  assign rsp_err  = rspErr_q;
  assign unit_a   = unitA_q;
  assign unit_b   = unitB_q;
  assign unit_ft  = unitFt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: an instance with settle time 1 exercised by
// directed and random operations against a transaction-level model, plus a
// second instance with settle time 4 for latency checks.
module tb_logic_unit_arbiter;

  localparam int W = 32;

  logic clk;
  logic reset;

  logic [1:0]   reqValid, reqReady, rspValid, rspReady;
  logic [3:0]   reqFt0, reqFt1, unitFt;
  logic [W-1:0] reqA0, reqA1, reqB0, reqB1, rspData, unitA, unitB, unitS;
  logic         rspErr;

  logic [1:0]   bReqValid, bReqReady, bRspValid, bRspReady;
  logic [3:0]   bReqFt0, bReqFt1, bUnitFt;
  logic [W-1:0] bReqA0, bReqA1, bReqB0, bReqB1, bRspData, bUnitA, bUnitB, bUnitS;
  logic         bRspErr;

  int  checks = 0;
  int  errors = 0;
  bit  modelPrio;

  // Behavioural logic unit: illegal codes return 1
  function automatic logic [W-1:0] unitModel(input logic [3:0] ft, input logic [W-1:0] a, input logic [W-1:0] b);
    case (ft)
      4'b1000: return a & b;
      4'b1110: return a | b;
      4'b0110: return a ^ b;
      4'b0001: return ~(a | b);
      4'b1010: return a;
      default: return 32'h1;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] ft);
    return (ft == 4'b1000) || (ft == 4'b1110) || (ft == 4'b0110) || (ft == 4'b0001) || (ft == 4'b1010);
  endfunction

  assign unitS  = unitModel(unitFt, unitA, unitB);
  assign bUnitS = unitModel(bUnitFt, bUnitA, bUnitB);

  logic_unit_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_ft0(reqFt0), .req_ft1(reqFt1),
    .req_a0(reqA0), .req_a1(reqA1), .req_b0(reqB0), .req_b1(reqB1),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_data(rspData), .rsp_err(rspErr),
    .unit_a(unitA), .unit_b(unitB), .unit_ft(unitFt), .unit_s(unitS)
  );

  logic_unit_arbiter #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(bReqValid), .req_ready(bReqReady),
    .req_ft0(bReqFt0), .req_ft1(bReqFt1),
    .req_a0(bReqA0), .req_a1(bReqA1), .req_b0(bReqB0), .req_b1(bReqB1),
    .rsp_valid(bRspValid), .rsp_ready(bRspReady),
    .rsp_data(bRspData), .rsp_err(bRspErr),
    .unit_a(bUnitA), .unit_b(bUnitB), .unit_ft(bUnitFt), .unit_s(bUnitS)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [3:0] ft0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [3:0] ft1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    reqValid = valid;
    reqFt0 = ft0; reqA0 = a0; reqB0 = b0;
    reqFt1 = ft1; reqA1 = a1; reqB1 = b1;
  endtask

  // One complete operation on the settle-1 instance; entered just after a rising edge with the DUT idle
  task automatic runOp(input string tag, input logic [1:0] valid,
                       input logic [3:0] ft0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [3:0] ft1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int rspDelay, input bit keepValid);
    bit           w;
    logic [1:0]   onehot;
    logic [3:0]   eFt;
    logic [W-1:0] eA, eB, eData;
    logic         eErr;
    applyStimulus(valid, ft0, a0, b0, ft1, a1, b1);
    if (valid == 2'b01)      w = 1'b0;
    else if (valid == 2'b10) w = 1'b1;
    else                     w = modelPrio;
    onehot = w ? 2'b10 : 2'b01;
    eFt    = w ? ft1 : ft0;
    eA     = w ? a1 : a0;
    eB     = w ? b1 : b0;
    eData  = unitModel(eFt, eA, eB);
    eErr   = !isLegal(eFt);
    @(negedge clk);
    checkOutput({tag, ".req_ready"}, 32'(reqReady), 32'(onehot));
    checkOutput({tag, ".idle_rsp_valid"}, 32'(rspValid), 32'd0);
    @(posedge clk); #1;
    modelPrio = ~w;
    if (!keepValid) reqValid = 2'b00;
    @(negedge clk);
    checkOutput({tag, ".exec_rsp_valid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, ".exec_req_ready"}, 32'(reqReady), 32'd0);
    checkOutput({tag, ".unit_ft"}, 32'(unitFt), 32'(eFt));
    checkOutput({tag, ".unit_a"}, unitA, eA);
    checkOutput({tag, ".unit_b"}, unitB, eB);
    @(posedge clk); #1;
    for (int d = 0; d <= rspDelay; d++) begin
      rspReady = (d == rspDelay) ? onehot : ~onehot;
      @(negedge clk);
      checkOutput({tag, ".rsp_valid"}, 32'(rspValid), 32'(onehot));
      checkOutput({tag, ".rsp_data"}, rspData, eData);
      checkOutput({tag, ".rsp_err"}, 32'(rspErr), 32'(eErr));
      checkOutput({tag, ".resp_req_ready"}, 32'(reqReady), 32'd0);
      checkOutput({tag, ".resp_unit_ft"}, 32'(unitFt), 32'(eFt));
      @(posedge clk); #1;
    end
    rspReady = 2'b00;
  endtask

  logic [3:0] legalFts [5];
  logic [3:0] rFt0, rFt1;
  logic [1:0] rValid;

  // Directed steps followed by random operations
  initial begin
    legalFts = '{4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b1010};
    modelPrio = 1'b0;
    reset = 1'b1;
    rspReady = 2'b00;
    applyStimulus(2'b00, 4'h0, '0, '0, 4'h0, '0, '0);
    bReqValid = 2'b00; bRspReady = 2'b00;
    bReqFt0 = 4'h0; bReqFt1 = 4'h0;
    bReqA0 = '0; bReqA1 = '0; bReqB0 = '0; bReqB1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] reset released");

    @(negedge clk);
    checkOutput("rst.req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst.rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst.rsp_data", rspData, 32'd0);
    checkOutput("rst.rsp_err", 32'(rspErr), 32'd0);
    checkOutput("rst.unit_a", unitA, 32'd0);
    checkOutput("rst.unit_b", unitB, 32'd0);
    checkOutput("rst.unit_ft", 32'(unitFt), 32'hA);
    checkOutput("rst4.unit_ft", 32'(bUnitFt), 32'hA);
    @(posedge clk); #1;

    runOp("and", 2'b01, 4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 4'h0, '0, '0, 0, 0);
    checkOutput("and.expected_const", unitModel(4'b1000, 32'hF0F0F0F0, 32'hFF00FF00), 32'hF000F000);

    for (int i = 0; i < 4; i++)
      runOp("contend", 2'b11, 4'b0110, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0001, 32'h0, 32'h0, 0, 1);
    reqValid = 2'b00;

    runOp("stall", 2'b10, 4'h0, '0, '0, 4'b1010, 32'h12345678, 32'h0, 5, 0);
    runOp("illegal", 2'b01, 4'b0011, 32'hDEADBEEF, 32'h0, 4'h0, '0, '0, 1, 0);

    bReqValid = 2'b01; bReqFt0 = 4'b1110; bReqA0 = 32'h1; bReqB0 = 32'h2;
    @(negedge clk);
    checkOutput("s4.req_ready", 32'(bReqReady), 32'd1);
    @(posedge clk); #1;
    bReqValid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("s4.exec_rsp_valid", 32'(bRspValid), 32'd0);
      checkOutput("s4.unit_ft", 32'(bUnitFt), 32'hE);
      checkOutput("s4.unit_a", bUnitA, 32'h1);
      checkOutput("s4.unit_b", bUnitB, 32'h2);
      @(posedge clk); #1;
    end
    bRspReady = 2'b01;
    @(negedge clk);
    checkOutput("s4.rsp_valid", 32'(bRspValid), 32'd1);
    checkOutput("s4.rsp_data", bRspData, 32'h3);
    checkOutput("s4.rsp_err", 32'(bRspErr), 32'd0);
    @(posedge clk); #1;
    bRspReady = 2'b00;
    @(negedge clk);
    checkOutput("s4.done_rsp_valid", 32'(bRspValid), 32'd0);
    @(posedge clk); #1;

    applyStimulus(2'b01, 4'b1000, 32'hFFFFFFFF, 32'h0000FFFF, 4'h0, '0, '0);
    @(negedge clk);
    checkOutput("abort.req_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 2'b00;
    reset = 1'b1;
    rspReady = 2'b11;
    @(posedge clk); #1;
    reset = 1'b0;
    modelPrio = 1'b0;
    @(negedge clk);
    checkOutput("abort.unit_ft", 32'(unitFt), 32'hA);
    checkOutput("abort.unit_a", unitA, 32'd0);
    checkOutput("abort.rsp_data", rspData, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort.rsp_valid", 32'(rspValid), 32'd0);
    end
    @(posedge clk); #1;
    rspReady = 2'b00;
    runOp("post_rst_prio", 2'b11, 4'b1110, 32'h00F0, 32'h0F00, 4'b1000, 32'h1, 32'h1, 0, 0);
    runOp("post_rst_req1", 2'b10, 4'h0, '0, '0, 4'b0001, 32'hAAAA5555, 32'h0000FFFF, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rValid = 2'($urandom_range(1, 3));
      rFt0 = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legalFts[$urandom_range(0, 4)];
      rFt1 = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legalFts[$urandom_range(0, 4)];
      runOp("rand", rValid, rFt0, $urandom, $urandom, rFt1, $urandom, $urandom,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    reqValid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
